// File: rtl/mac_operand_sequencer.sv
// Operand sequencer for a streaming MAC: buffers {a,b} pairs in a small FIFO and
// runs one dot-product job (clear, issue len pairs, drain, finalize, collect result).
module mac_operand_sequencer #(
  parameter int DEPTH     = 8,
  parameter int DRAIN_MAX = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [7:0]  in_a,
  input  logic signed [7:0]  in_b,
  output logic               mac_en,
  output logic signed [7:0]  mac_a,
  output logic signed [7:0]  mac_b,
  output logic               mac_clr,
  output logic               mac_finalize,
  input  logic               mult_valid,
  input  logic               mac_out_valid,
  input  logic signed [15:0] mac_out,
  output logic signed [15:0] result,
  output logic               done,
  output logic               busy,
  output logic               err
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(DRAIN_MAX + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CLEAR    = 3'd1;
  localparam logic [2:0] S_ISSUE    = 3'd2;
  localparam logic [2:0] S_DRAIN    = 3'd3;
  localparam logic [2:0] S_FINAL    = 3'd4;
  localparam logic [2:0] S_WAIT_OUT = 3'd5;

  logic [15:0]        mem [DEPTH];
  logic [AW:0]        wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]        occupancy;
  logic               fifo_full, fifo_empty, push, pop;

  logic [2:0]         state_reg, state_next;
  logic [7:0]         len_reg, issued_reg, prod_cnt_reg;
  logic [DW-1:0]      drain_cnt_reg;
  logic               products_done, drain_expired;

  logic               mac_en_reg, mac_clr_reg, mac_finalize_reg, done_reg, err_reg;
  logic signed [7:0]  mac_a_reg, mac_b_reg;
  logic signed [15:0] result_reg;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign occupancy  = wr_ptr_reg - rd_ptr_reg;
  assign fifo_full  = (occupancy == (AW + 1)'(DEPTH));
  assign fifo_empty = (occupancy == '0);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full;
  assign pop        = (state_reg == S_ISSUE) && !fifo_empty && (issued_reg < len_reg);

  assign products_done = (prod_cnt_reg == len_reg);
  assign drain_expired = (drain_cnt_reg == DW'(DRAIN_MAX - 1));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= {in_a, in_b};
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:     if (start) state_next = S_CLEAR;
      S_CLEAR:    state_next = (len_reg != 8'd0) ? S_ISSUE : S_FINAL;
      S_ISSUE:    if (pop && (issued_reg + 8'd1 == len_reg)) state_next = S_DRAIN;
      S_DRAIN:    if (products_done || drain_expired) state_next = S_FINAL;
      S_FINAL:    state_next = S_WAIT_OUT;
      S_WAIT_OUT: if (mac_out_valid) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      len_reg          <= '0;
      issued_reg       <= '0;
      prod_cnt_reg     <= '0;
      drain_cnt_reg    <= '0;
      mac_en_reg       <= 1'b0;
      mac_clr_reg      <= 1'b0;
      mac_finalize_reg <= 1'b0;
      mac_a_reg        <= '0;
      mac_b_reg        <= '0;
      result_reg       <= '0;
      done_reg         <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      state_reg        <= state_next;
      mac_en_reg       <= pop;
      mac_clr_reg      <= (state_reg == S_CLEAR);
      mac_finalize_reg <= (state_reg == S_FINAL);
      done_reg         <= (state_reg == S_WAIT_OUT) && mac_out_valid;
      drain_cnt_reg    <= (state_reg == S_DRAIN) ? drain_cnt_reg + 1'b1 : '0;

      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      // Popped pair is read straight into the operand registers; they hold otherwise.
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        issued_reg <= issued_reg + 8'd1;
        mac_a_reg  <= mem[rd_ptr_reg[AW-1:0]][15:8];
        mac_b_reg  <= mem[rd_ptr_reg[AW-1:0]][7:0];
      end

      if ((state_reg == S_ISSUE || state_reg == S_DRAIN) && mult_valid &&
          (prod_cnt_reg < len_reg)) begin
        prod_cnt_reg <= prod_cnt_reg + 8'd1;
      end

      if (state_reg == S_DRAIN && !products_done && drain_expired) begin
        err_reg <= 1'b1;
      end

      if (state_reg == S_IDLE && start) begin
        len_reg      <= len;
        issued_reg   <= '0;
        prod_cnt_reg <= '0;
        err_reg      <= 1'b0;
      end

      if (state_reg == S_WAIT_OUT && mac_out_valid) begin
        result_reg <= mac_out;
      end
    end
  end

  assign mac_en       = mac_en_reg;
  assign mac_a        = mac_a_reg;
  assign mac_b        = mac_b_reg;
  assign mac_clr      = mac_clr_reg;
  assign mac_finalize = mac_finalize_reg;
  assign result       = result_reg;
  assign done         = done_reg;
  assign err          = err_reg;
  assign busy         = (state_reg != S_IDLE);

endmodule
